// File: rtl/sim_exit_reporter.sv
// End-of-run reporter for a simulation harness: accepts an exit request or raises a cycle-limit
// timeout, drains for a fixed interval, then pulses done once and (in simulation) ends the run.
module sim_exit_reporter #(
  parameter int                 CODE_W       = 32,
  parameter int                 CYC_W        = 64,
  parameter int                 DRAIN_CYCLES = 16,
  parameter logic [CODE_W-1:0]  TIMEOUT_CODE = CODE_W'('hDEAD),
  // Lets a bench that checks the report keep running past it; harnesses leave this at 1.
  parameter bit                 FINISH_EN    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic              draining,
  output logic              done,
  output logic [CODE_W-1:0] exit_code,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [7:0] drain_cnt;
  logic       accept;
  logic       timeout_hit;

  // req_ready is only ever high while in IDLE, so it alone qualifies an accept.
  assign accept      = req_valid && req_ready;
  assign timeout_hit = (state == S_IDLE) && (max_cycles != '0) &&
                       (cycle_count >= max_cycles - CYC_W'(1));

  always_comb begin
    // NOTE: default first so every path assigns state_nx; otherwise a latch is inferred.
    state_nx = state;
    case (state)
      S_IDLE:   if (accept || timeout_hit) state_nx = S_DRAIN;
      S_DRAIN:  if (drain_cnt == 8'd0)     state_nx = S_REPORT;
      S_REPORT: state_nx = S_HALT;
      default:  state_nx = S_HALT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
    if (reset) begin
      state       <= S_IDLE;
      drain_cnt   <= 8'd0;
      req_ready   <= 1'b0;
      draining    <= 1'b0;
      done        <= 1'b0;
      exit_code   <= '0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= (state_nx == S_IDLE);
      draining  <= (state_nx == S_DRAIN);
      done      <= (state_nx == S_REPORT);

      if (cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);

      if (state == S_IDLE) begin
        if (accept) begin
          exit_code <= req_code;
          timed_out <= 1'b0;
          drain_cnt <= DRAIN_LOAD;
        end else if (timeout_hit) begin
          exit_code <= TIMEOUT_CODE;
          timed_out <= 1'b1;
          drain_cnt <= DRAIN_LOAD;
        end
      end else if (state == S_DRAIN && drain_cnt != 8'd0) begin
        drain_cnt <= drain_cnt - 8'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && done) begin
      $display("[sim_exit_reporter] exit_code=0x%0h cycle_count=%0d timed_out=%0b",
               exit_code, cycle_count, timed_out);
      if (FINISH_EN) $finish;
    end
  end
`endif

endmodule
